bcd_stopwatch: RTL and testbench
================================

# bcd_stopwatch

Four-digit BCD stopwatch counter that produces the digit values consumed by the team's 4-digit multiplexed seven-segment display driver. It sits directly upstream of that driver: its `s3..s0` outputs wire straight into the driver's digit inputs, and both blocks share one clock and reset. It debounces two push buttons, runs a start/pause/clear state machine, and counts seconds and hundredths from 00.00 to 59.99 on a prescaled tick.

## Interface
- `TICK_DIV`, default 100000: clock cycles per hundredth-second increment (≥2).
- `DEB_LEN`, default 20000: consecutive stable synchronized cycles needed to accept a button level change (≥2).
- `clk` input, 1 bit: system clock, rising edge.
- `clrn` input, 1 bit: reset. Asynchronous and active-low.
- `btn_ss` input, 1 bit: raw start/stop button, asynchronous, active-high.
- `btn_clr` input, 1 bit: raw clear button, asynchronous, active-high.
- `s3` output, 4 bits: tens of seconds, BCD 0–5.
- `s2` output, 4 bits: seconds, BCD 0–9.
- `s1` output, 4 bits: tenths, BCD 0–9.
- `s0` output, 4 bits: hundredths, BCD 0–9.
- `running` output, 1 bit: high in RUN state.
- `ovf` output, 1 bit: one-cycle pulse on wrap 59.99→00.00.

## Operation
- Button path (per button, identical):
  - 2-flop synchronizer.
  - Debounce counter holds a stable level. The counter resets whenever the synced value equals the stable level.
  - The stable level flips when the synced value has differed for DEB_LEN consecutive cycles.
  - A press event is a one-cycle pulse on a 0→1 flip of the stable level. Releases generate no event.
- FSM states: IDLE (digits zero, stopped), RUN, PAUSE.
  - IDLE + ss event → RUN. The prescaler is cleared to 0.
  - RUN + ss event → PAUSE. The prescaler and digits hold.
  - PAUSE + ss event → RUN. The prescaler resumes from its held value.
  - PAUSE + clr event → IDLE. Digits and prescaler are cleared.
  - IDLE + clr event → IDLE (no change).
  - RUN + clr event → ignored.
  - Simultaneous ss and clr events:
    - In PAUSE, clr wins → IDLE.
    - In RUN, ss wins → PAUSE.
    - In IDLE, ss wins → RUN.
- Prescaler: counts 0..TICK_DIV-1 only in RUN. Width is $clog2(TICK_DIV). The tick is asserted when the count equals TICK_DIV-1, and the count then wraps to 0.
- Digit increment on tick, as a BCD ripple:
  - s0 9→0 carries into s1; s1 9→0 carries into s2; s2 9→0 carries into s3; s3 5→0 wraps.
  - Digits never hold non-BCD values. s3 never exceeds 5.
- Wrap: on a tick at 59.99 the digits go to 00.00, `ovf` pulses for that cycle, and the state stays RUN.

## Timing
- Reset (`clrn`=0, asynchronous):
  - State IDLE.
  - s3..s0 = 0; `running` = 0; `ovf` = 0.
  - Prescaler, debounce counters and synchronizers are cleared.
  - Stable button levels are 0.
- Reset mid-count takes effect immediately, without waiting for a clock edge. After release, the block stays in IDLE until a new ss event.
- Button latency: a raw level held from edge N is captured by the synchronizer output at edge N+2. The stable level flips at edge N+2+DEB_LEN. The press event is high for the following cycle. The state register updates at the next edge, N+3+DEB_LEN.
- `running` is registered and changes on the same edge as the state.
- First increment after IDLE→RUN: the tick occurs in the TICK_DIV-th RUN cycle. Digits show 00.01 after edge TICK_DIV following the transition edge.
- Digits update on the edge ending the tick cycle. `ovf` is registered and is high for exactly the one cycle after the wrap edge.
- Pausing on the same edge as a tick: that tick's increment is applied, and the state becomes PAUSE.
- All outputs are registered, with no combinational path from the buttons.

## Test plan
Bench parameters: TICK_DIV=4, DEB_LEN=3.

- Reset: hold `clrn`=0 for 2 cycles → s3..s0=0, running=0, ovf=0. Release, no buttons → digits stay 0000 for 50 cycles.
- Start and count: press ss for 10 cycles → running=1 at N+6. Digits read 00.01 4 cycles later, and 00.10 after 40 RUN cycles.
- Bounce rejection: toggle btn_ss every 2 cycles for 20 cycles → no state change, running stays 0.
- Pause, resume, clear:
  - ss press in RUN → running=0, digits frozen.
  - clr press → 00.00, state IDLE.
  - clr press during RUN → count continues unaffected.
- Wrap: count to 59.99 (5999 ticks, or preload via long run) → next tick gives 00.00, ovf high for exactly 1 cycle, running stays 1.
- Async reset mid-run: drop `clrn` between clock edges at 12.34 → outputs are 0 before the next edge. After release the block stays IDLE with digits 0000.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (00.00 .. 59.99) with debounced start/stop and
// clear buttons. Its s3..s0 digit outputs feed a multiplexed seven-segment
// driver. Every output comes straight from a flop.
module bcd_stopwatch #(
   parameter int TICK_DIV = 100000,
   parameter int DEB_LEN  = 20000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       btn_ss,
   input  logic       btn_clr,
   output logic [3:0] s3,
   output logic [3:0] s2,
   output logic [3:0] s1,
   output logic [3:0] s0,
   output logic       running,
   output logic       ovf
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEB_LEN > 2) ? $clog2(DEB_LEN) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   // BCD ripple increment. Bit 16 flags the 59.99 -> 00.00 wrap.
   // Out-of-range digits are folded to 0 so a corrupted digit self-heals.
   function automatic logic [16:0] bcd_inc(input logic [15:0] d);
      logic [15:0] n;
      logic        w;
      n = d;
      w = 1'b0;
      if (d[3:0] < 4'd9) begin
         n[3:0] = d[3:0] + 4'd1;
      end else begin
         n[3:0] = 4'd0;
         if (d[7:4] < 4'd9) begin
            n[7:4] = d[7:4] + 4'd1;
         end else begin
            n[7:4] = 4'd0;
            if (d[11:8] < 4'd9) begin
               n[11:8] = d[11:8] + 4'd1;
            end else begin
               n[11:8] = 4'd0;
               if (d[15:12] < 4'd5) begin
                  n[15:12] = d[15:12] + 4'd1;
               end else begin
                  n[15:12] = 4'd0;
                  w        = 1'b1;
               end
            end
         end
      end
      return {w, n};
   endfunction

   // Index 0 is start/stop, index 1 is clear.
   logic [1:0]    raw_s;
   logic [1:0]    sync1_r;
   logic [1:0]    sync2_r;
   logic [1:0]    stable_r;
   logic [1:0]    press_r;
   logic [DW-1:0] deb_cnt_r [2];

   state_t        state_r;
   state_t        state_nxt_s;
   logic [PW-1:0] presc_r;
   logic [15:0]   digits_r;
   logic [16:0]   inc_s;
   logic          running_r;
   logic          ovf_r;
   logic          ss_ev_s;
   logic          clr_ev_s;
   logic          tick_s;
   logic          start_s;
   logic          clear_s;

   assign raw_s    = {btn_clr, btn_ss};
   assign ss_ev_s  = press_r[0];
   assign clr_ev_s = press_r[1];
   assign tick_s   = (state_r == ST_RUN) && (presc_r == PRESC_MAX);
   assign start_s  = (state_r == ST_IDLE) && ss_ev_s;
   assign clear_s  = (state_r == ST_PAUSE) && clr_ev_s;
   assign inc_s    = bcd_inc(digits_r);

   // Two-flop synchronizers for both raw buttons.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync1_r <= 2'b00;
         sync2_r <= 2'b00;
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
      end
   end

   // Debounce: flip the stable level after DEB_LEN consecutive differing
   // synced samples; a 0->1 flip yields a one-cycle press pulse.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         stable_r <= 2'b00;
         press_r  <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            deb_cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_r[i] == stable_r[i]) begin
               deb_cnt_r[i] <= '0;
               press_r[i]   <= 1'b0;
            end else if (deb_cnt_r[i] == DEB_MAX) begin
               deb_cnt_r[i] <= '0;
               stable_r[i]  <= ~stable_r[i];
               press_r[i]   <= ~stable_r[i];
            end else begin
               deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
               press_r[i]   <= 1'b0;
            end
         end
      end
   end

   // Next-state logic; ss beats clr except in PAUSE, where clr wins.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ss_ev_s) state_nxt_s = ST_RUN;
            else         state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (ss_ev_s) state_nxt_s = ST_PAUSE;
            else         state_nxt_s = ST_RUN;
         end
         ST_PAUSE: begin
            if (clr_ev_s)     state_nxt_s = ST_IDLE;
            else if (ss_ev_s) state_nxt_s = ST_RUN;
            else              state_nxt_s = ST_PAUSE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register plus the registered running flag that tracks it.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_r   <= ST_IDLE;
         running_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         running_r <= (state_nxt_s == ST_RUN);
      end
   end

   // Prescaler: advances only in RUN, holds in PAUSE, zeroed on start/clear.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         presc_r <= '0;
      end else if (start_s || clear_s || tick_s) begin
         presc_r <= '0;
      end else if (state_r == ST_RUN) begin
         presc_r <= presc_r + PW'(1);
      end else begin
         presc_r <= presc_r;
      end
   end

   // Digit counter and the one-cycle wrap pulse.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         digits_r <= 16'h0000;
         ovf_r    <= 1'b0;
      end else if (clear_s) begin
         digits_r <= 16'h0000;
         ovf_r    <= 1'b0;
      end else if (tick_s) begin
         digits_r <= inc_s[15:0];
         ovf_r    <= inc_s[16];
      end else begin
         digits_r <= digits_r;
         ovf_r    <= 1'b0;
      end
   end

   assign s3      = digits_r[15:12];
   assign s2      = digits_r[11:8];
   assign s1      = digits_r[7:4];
   assign s0      = digits_r[3:0];
   assign running = running_r;
   assign ovf     = ovf_r;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch with TICK_DIV=4, DEB_LEN=3.
// The reference tracks total RUN cycles as an integer and derives digits by
// division; button acceptance is a sliding-window rule over raw samples.
module tb_bcd_stopwatch;

   localparam int TD = 4;
   localparam int DL = 3;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       btn_ss = 1'b0;
   logic       btn_clr = 1'b0;
   logic [3:0] s3, s2, s1, s0;
   logic       running, ovf;
   logic [15:0] dig;
   int checks = 0;
   int errors = 0;

   bcd_stopwatch #(.TICK_DIV(TD), .DEB_LEN(DL)) dut (
      .clk(clk), .clrn(clrn), .btn_ss(btn_ss), .btn_clr(btn_clr),
      .s3(s3), .s2(s2), .s1(s1), .s0(s0), .running(running), .ovf(ovf)
   );

   always #5 clk = ~clk;
   assign dig = {s3, s2, s1, s0};

   // ---------------- reference model ----------------
   int          m_state;   // 0 idle, 1 run, 2 pause
   int          m_run;     // RUN cycles since last clear
   logic        m_ovf;
   logic [DL:0] ss_hist, clr_hist;
   logic        ss_stab, clr_stab, ss_ev, clr_ev;
   logic [15:0] m_dig;
   logic        m_running;

   function automatic logic [15:0] to_bcd(input int v);
      int w;
      w = v % 6000;
      return {4'(w / 1000), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
   endfunction

   assign m_dig     = to_bcd(m_run / TD);
   assign m_running = (m_state == 1);

   // Model: a level is accepted when the DL samples seen two edges late all differ from it.
   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         m_state <= 0; m_run <= 0; m_ovf <= 1'b0;
         ss_hist <= '0; clr_hist <= '0;
         ss_stab <= 1'b0; clr_stab <= 1'b0; ss_ev <= 1'b0; clr_ev <= 1'b0;
      end else begin
         ss_hist  <= {ss_hist[DL-1:0], btn_ss};
         clr_hist <= {clr_hist[DL-1:0], btn_clr};
         if (ss_stab ? (ss_hist[DL:1] == '0) : (ss_hist[DL:1] == '1)) begin
            ss_stab <= ~ss_stab; ss_ev <= ~ss_stab;
         end else begin
            ss_ev <= 1'b0;
         end
         if (clr_stab ? (clr_hist[DL:1] == '0) : (clr_hist[DL:1] == '1)) begin
            clr_stab <= ~clr_stab; clr_ev <= ~clr_stab;
         end else begin
            clr_ev <= 1'b0;
         end
         if (m_state == 1) begin
            m_run <= m_run + 1;
            m_ovf <= ((m_run + 1) % (TD * 6000)) == 0;
         end else begin
            m_ovf <= 1'b0;
            if (m_state == 2 && clr_ev) m_run <= 0;
         end
         case (m_state)
            0: if (ss_ev) m_state <= 1;
            1: if (ss_ev) m_state <= 2;
            2: if (clr_ev) m_state <= 0; else if (ss_ev) m_state <= 1;
            default: m_state <= 0;
         endcase
      end
   end

   // Drive both buttons, then advance to the next falling edge.
   task automatic cyc(input logic ss, input logic clr);
      btn_ss = ss; btn_clr = clr;
      @(negedge clk);
   endtask

   task automatic test_reset;
      clrn = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (dig !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h exp 0000", dig); end
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b exp 0", running); end
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
      clrn = 1'b1;
      for (int c = 0; c < 50; c++) begin
         cyc(1'b0, 1'b0);
         checks++;
         if (dig !== 16'h0000 || running !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got %h/%b exp 0000/0", dig, running);
         end
      end
   endtask

   task automatic test_bounce;
      for (int c = 0; c < 30; c++) begin
         cyc((c < 20) && ((c / 2) % 2 == 0), 1'b0);
         checks++;
         if (running !== 1'b0 || dig !== 16'h0000 || running !== m_running) begin
            errors++; $display("FAIL bounce: got %h/%b exp 0000/0", dig, running);
         end
      end
   endtask

   task automatic test_start;
      for (int k = 1; k <= 50; k++) begin
         cyc(k <= 10, 1'b0);
         checks++;
         if (running !== (k >= 6)) begin
            errors++; $display("FAIL start_latency k=%0d: got %b exp %b", k, running, (k >= 6));
         end
         if (k == 9 || k == 10 || k == 45 || k == 46) begin
            checks++;
            if (dig !== ((k == 9) ? 16'h0000 : (k == 10) ? 16'h0001 : (k == 45) ? 16'h0009 : 16'h0010)) begin
               errors++; $display("FAIL start_digits k=%0d: got %h", k, dig);
            end
         end
         checks++;
         if ({dig, running, ovf} !== {m_dig, m_running, m_ovf}) begin
            errors++; $display("FAIL start_model: got %h/%b/%b exp %h/%b/%b", dig, running, ovf, m_dig, m_running, m_ovf);
         end
      end
   endtask

   task automatic test_pause_resume_clear;
      logic [15:0] frozen;
      // pause
      for (int k = 1; k <= 12; k++) begin
         cyc(k <= 5, 1'b0);
         if (k == 6) begin
            checks++;
            if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b exp 0", running); end
         end
         checks++;
         if ({dig, running, ovf} !== {m_dig, m_running, m_ovf}) begin
            errors++; $display("FAIL pause_model: got %h/%b/%b exp %h/%b/%b", dig, running, ovf, m_dig, m_running, m_ovf);
         end
      end
      frozen = dig;
      for (int k = 0; k < 20; k++) begin
         cyc(1'b0, 1'b0);
         checks++;
         if (dig !== frozen || running !== 1'b0) begin
            errors++; $display("FAIL pause_frozen: got %h/%b exp %h/0", dig, running, frozen);
         end
      end
      // resume, then clr while running, then pause and clear
      for (int k = 1; k <= 54; k++) begin
         if (k <= 12)      cyc(k <= 5, 1'b0);
         else if (k <= 30) cyc(1'b0, k <= 17);
         else if (k <= 42) cyc(k <= 35, 1'b0);
         else              cyc(1'b0, k <= 47);
         if (k == 6 || (k > 12 && k <= 30)) begin
            checks++;
            if (running !== 1'b1) begin errors++; $display("FAIL resume_running k=%0d: got %b exp 1", k, running); end
         end
         if (k == 48) begin
            checks++;
            if (dig !== 16'h0000 || running !== 1'b0) begin
               errors++; $display("FAIL clear_idle: got %h/%b exp 0000/0", dig, running);
            end
         end
         checks++;
         if ({dig, running, ovf} !== {m_dig, m_running, m_ovf}) begin
            errors++; $display("FAIL prc_model k=%0d: got %h/%b/%b exp %h/%b/%b", k, dig, running, ovf, m_dig, m_running, m_ovf);
         end
      end
   endtask

   task automatic test_random;
      int c = 0;
      while (c < 3000) begin
         int   sel, hold, gap;
         logic ss, clr;
         sel  = $urandom_range(0, 3);
         hold = $urandom_range(1, 8);
         gap  = $urandom_range(1, 10);
         ss   = (sel == 1 || sel == 3);
         clr  = (sel == 2 || sel == 3);
         for (int h = 0; h < hold + gap; h++) begin
            if (h < hold) cyc(ss, clr);
            else          cyc(1'b0, 1'b0);
            c++;
            checks++;
            if ({dig, running, ovf} !== {m_dig, m_running, m_ovf}) begin
               errors++; $display("FAIL random_model c=%0d: got %h/%b/%b exp %h/%b/%b", c, dig, running, ovf, m_dig, m_running, m_ovf);
            end
         end
      end
   endtask

   task automatic test_wrap;
      int          ovf_cnt = 0;
      logic        done = 1'b0;
      logic [15:0] prev_dig;
      btn_ss = 1'b0; btn_clr = 1'b0; clrn = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      for (int k = 1; k <= 10; k++) cyc(k <= 5, 1'b0);
      prev_dig = dig;
      for (int c = 0; c < 24200; c++) begin
         cyc(1'b0, 1'b0);
         checks++;
         if ({dig, running, ovf} !== {m_dig, m_running, m_ovf}) begin
            errors++; $display("FAIL wrap_model: got %h/%b/%b exp %h/%b/%b", dig, running, ovf, m_dig, m_running, m_ovf);
         end
         if (ovf === 1'b1) begin
            ovf_cnt++;
            checks++;
            if (dig !== 16'h0000 || prev_dig !== 16'h5999 || running !== 1'b1) begin
               errors++; $display("FAIL wrap_edge: got %h->%h run %b exp 5999->0000 run 1", prev_dig, dig, running);
            end
         end
         prev_dig = dig;
         if (m_run >= TD * 6000 + 8) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (done !== 1'b1 || ovf_cnt != 1) begin
         errors++; $display("FAIL wrap_pulses: got %0d pulses (done %b) exp 1", ovf_cnt, done);
      end
      checks++;
      if (running !== 1'b1 || dig !== 16'h0002) begin
         errors++; $display("FAIL wrap_after: got %h/%b exp 0002/1", dig, running);
      end
   endtask

   task automatic test_async_reset;
      logic found = 1'b0;
      for (int k = 1; k <= 34; k++) begin
         if (k <= 12)      cyc(k <= 5, 1'b0);
         else if (k <= 24) cyc(1'b0, k <= 17);
         else              cyc(k <= 29, 1'b0);
      end
      for (int c = 0; c < 6000; c++) begin
         cyc(1'b0, 1'b0);
         if (m_dig === 16'h1234) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (found !== 1'b1 || dig !== 16'h1234 || running !== 1'b1) begin
         errors++; $display("FAIL async_reach: got %h/%b found %b exp 1234/1", dig, running, found);
      end
      @(posedge clk);
      #2;
      clrn = 1'b0;
      #1;
      checks++;
      if (dig !== 16'h0000 || running !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL async_reset: got %h/%b/%b exp 0000/0/0", dig, running, ovf);
      end
      @(negedge clk);
      clrn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         cyc(1'b0, 1'b0);
         checks++;
         if (dig !== 16'h0000 || running !== 1'b0) begin
            errors++; $display("FAIL async_after: got %h/%b exp 0000/0", dig, running);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_bounce();
      test_start();
      test_pause_resume_clear();
      test_random();
      test_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
